// File: rtl/id_buf_pkg.sv
// ---------------------------------------------------------------------------
// id_buf_pkg
//   Shared definitions for the dual-issue ID buffer.
//   - NOP_INST : encoding an empty slot presents on ID_inst (all zeros, so
//                hazard compares against register 0 are inert)
//   - WAY0/WAY1: way index constants used to address the two slots
//   - slot_t   : {valid, inst, pc} view of one slot at the default widths
// ---------------------------------------------------------------------------
package id_buf_pkg;

    localparam int INST_W_DEF = 32;
    localparam int PC_W_DEF   = 32;

    localparam logic [INST_W_DEF-1:0] NOP_INST = '0;

    localparam logic WAY0 = 1'b0;
    localparam logic WAY1 = 1'b1;

    typedef struct packed {
        logic                  valid;
        logic [INST_W_DEF-1:0] inst;
        logic [PC_W_DEF-1:0]   pc;
    } slot_t;

endpackage

// File: rtl/id_slot.sv
// ---------------------------------------------------------------------------
// id_slot
//   One ID-stage instruction slot. Clear wins over load; an empty slot
//   always presents NOP_INST and a zero PC.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     load              capture new_inst/new_pc and mark the slot valid
//     clear             empty the slot
//     new_inst, new_pc  incoming instruction and PC
//     valid, inst, pc   registered slot contents
// ---------------------------------------------------------------------------
module id_slot
    import id_buf_pkg::*;
#(
    parameter int INST_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [INST_W-1:0] new_inst,
    input  logic [PC_W-1:0]   new_pc,
    output logic              valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   pc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
            inst  <= INST_W'(NOP_INST);
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= new_inst;
            pc    <= new_pc;
        end
    end

endmodule

// File: rtl/dual_issue_id_buffer.sv
// ---------------------------------------------------------------------------
// dual_issue_id_buffer
//   Two-slot ID buffer for the 2-way in-order pipeline. Decides which ways
//   issue to EX given per-way stalls and a pipeline flush, holds stalled
//   instructions, refills freed slots from fetch in program order and tracks
//   which way holds the older instruction.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     IF_inst_0/1, IF_pc_0/1    fetched pair (entry 0 older)
//     IF_valid_0/1              fetch entry valid (1 implies 0)
//     hazard_detected_0/1       per-way stall request
//     Flush_0/1                 flush (asserted together)
//     ID_inst_0/1, ID_pc_0/1    slot contents (inst = NOP when empty)
//     ID_valid_0/1              slot occupied
//     Way_0_oldest_ID           1: way 0 holds the older instruction
//     issue_0/1                 way issues this cycle (combinational)
//     fetch_count               fetch entries consumed this cycle
//     stall_cnt, issue_cnt      performance counters (wrap)
// ---------------------------------------------------------------------------
module dual_issue_id_buffer
    import id_buf_pkg::*;
#(
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] IF_inst_0,
    input  logic [INST_W-1:0] IF_inst_1,
    input  logic [PC_W-1:0]   IF_pc_0,
    input  logic [PC_W-1:0]   IF_pc_1,
    input  logic              IF_valid_0,
    input  logic              IF_valid_1,
    input  logic              hazard_detected_0,
    input  logic              hazard_detected_1,
    input  logic              Flush_0,
    input  logic              Flush_1,
    output logic [INST_W-1:0] ID_inst_0,
    output logic [INST_W-1:0] ID_inst_1,
    output logic [PC_W-1:0]   ID_pc_0,
    output logic [PC_W-1:0]   ID_pc_1,
    output logic              ID_valid_0,
    output logic              ID_valid_1,
    output logic              Way_0_oldest_ID,
    output logic              issue_0,
    output logic              issue_1,
    output logic [1:0]        fetch_count,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  issue_cnt
);

    logic [1:0] valid;
    logic [1:0] hazard;
    logic [1:0] issue;
    logic [1:0] remain;
    logic [1:0] n_remain;
    logic [1:0] load;
    logic [1:0] clear;
    logic       flush;
    logic       oldest_way;
    logic       younger_way;
    logic       issue_old;
    logic       issue_young;
    logic       oldest_nxt;
    logic       slot1_from_entry1;

    logic [INST_W-1:0] slot1_new_inst;
    logic [PC_W-1:0]   slot1_new_pc;

    assign valid       = {ID_valid_1, ID_valid_0};
    assign hazard      = {hazard_detected_1, hazard_detected_0};
    assign flush       = Flush_0 | Flush_1;
    assign oldest_way  = Way_0_oldest_ID ? WAY0 : WAY1;
    assign younger_way = ~oldest_way;

    // In-order issue: the younger way may go only if the older one goes too
    // or the older slot is empty.
    always_comb begin
        issue_old   = 1'b0;
        issue_young = 1'b0;
        if (!rst && !flush) begin
            issue_old   = valid[oldest_way] & ~hazard[oldest_way];
            issue_young = valid[younger_way] & ~hazard[younger_way]
                          & (issue_old | ~valid[oldest_way]);
        end
    end

    always_comb begin
        issue              = 2'b00;
        issue[oldest_way]  = issue_old;
        issue[younger_way] = issue_young;
    end

    assign issue_0 = issue[0];
    assign issue_1 = issue[1];

    assign remain   = valid & ~issue;
    assign n_remain = {1'b0, remain[0]} + {1'b0, remain[1]};

    // Refill: a single survivor becomes the oldest and the free slot takes
    // fetch entry 0; with no survivors the pair loads straight across.
    always_comb begin
        load              = 2'b00;
        clear             = 2'b00;
        fetch_count       = 2'd0;
        oldest_nxt        = Way_0_oldest_ID;
        slot1_from_entry1 = 1'b0;
        if (flush) begin
            clear      = 2'b11;
            oldest_nxt = 1'b1;
        end else if (!rst) begin
            case (n_remain)
                2'd2: begin
                    oldest_nxt = Way_0_oldest_ID;
                end
                2'd1: begin
                    oldest_nxt  = remain[WAY0];
                    fetch_count = {1'b0, IF_valid_0};
                    if (IF_valid_0) begin
                        load = ~remain;
                    end else begin
                        clear = ~remain;
                    end
                end
                default: begin
                    oldest_nxt        = 1'b1;
                    slot1_from_entry1 = 1'b1;
                    load              = {IF_valid_1, IF_valid_0};
                    clear             = ~{IF_valid_1, IF_valid_0};
                    fetch_count       = {1'b0, IF_valid_0} + {1'b0, IF_valid_1};
                end
            endcase
        end
    end

    assign slot1_new_inst = slot1_from_entry1 ? IF_inst_1 : IF_inst_0;
    assign slot1_new_pc   = slot1_from_entry1 ? IF_pc_1   : IF_pc_0;

    id_slot #(
        .INST_W (INST_W),
        .PC_W   (PC_W)
    ) u_slot_0 (
        .clk      (clk),
        .rst      (rst),
        .load     (load[0]),
        .clear    (clear[0]),
        .new_inst (IF_inst_0),
        .new_pc   (IF_pc_0),
        .valid    (ID_valid_0),
        .inst     (ID_inst_0),
        .pc       (ID_pc_0)
    );

    id_slot #(
        .INST_W (INST_W),
        .PC_W   (PC_W)
    ) u_slot_1 (
        .clk      (clk),
        .rst      (rst),
        .load     (load[1]),
        .clear    (clear[1]),
        .new_inst (slot1_new_inst),
        .new_pc   (slot1_new_pc),
        .valid    (ID_valid_1),
        .inst     (ID_inst_1),
        .pc       (ID_pc_1)
    );

    // Flush cycles are not counted; issue is already forced low then.
    always_ff @(posedge clk) begin
        if (rst) begin
            Way_0_oldest_ID <= 1'b1;
            stall_cnt       <= '0;
            issue_cnt       <= '0;
        end else begin
            Way_0_oldest_ID <= oldest_nxt;
            if (!flush) begin
                issue_cnt <= issue_cnt + CNT_W'(issue[0]) + CNT_W'(issue[1]);
                if (|remain) begin
                    stall_cnt <= stall_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_id_buffer.sv
module tb_dual_issue_id_buffer;
    import id_buf_pkg::*;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 32;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SUB = 32'h40208233;
    localparam logic [31:0] I_A   = 32'h00100093;
    localparam logic [31:0] I_B   = 32'h00200113;
    localparam logic [31:0] I_C   = 32'h00300193;
    localparam logic [31:0] I_D   = 32'h00400213;
    localparam logic [31:0] I_E   = 32'h00500293;

    logic              clk = 1'b0;
    logic              rst;
    logic [INST_W-1:0] IF_inst_0, IF_inst_1;
    logic [PC_W-1:0]   IF_pc_0, IF_pc_1;
    logic              IF_valid_0, IF_valid_1;
    logic              hazard_detected_0, hazard_detected_1;
    logic              Flush_0, Flush_1;
    logic [INST_W-1:0] ID_inst_0, ID_inst_1;
    logic [PC_W-1:0]   ID_pc_0, ID_pc_1;
    logic              ID_valid_0, ID_valid_1;
    logic              Way_0_oldest_ID;
    logic              issue_0, issue_1;
    logic [1:0]        fetch_count;
    logic [CNT_W-1:0]  stall_cnt, issue_cnt;

    always #5 clk = ~clk;

    dual_issue_id_buffer #(
        .INST_W (INST_W),
        .PC_W   (PC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .IF_inst_0         (IF_inst_0),
        .IF_inst_1         (IF_inst_1),
        .IF_pc_0           (IF_pc_0),
        .IF_pc_1           (IF_pc_1),
        .IF_valid_0        (IF_valid_0),
        .IF_valid_1        (IF_valid_1),
        .hazard_detected_0 (hazard_detected_0),
        .hazard_detected_1 (hazard_detected_1),
        .Flush_0           (Flush_0),
        .Flush_1           (Flush_1),
        .ID_inst_0         (ID_inst_0),
        .ID_inst_1         (ID_inst_1),
        .ID_pc_0           (ID_pc_0),
        .ID_pc_1           (ID_pc_1),
        .ID_valid_0        (ID_valid_0),
        .ID_valid_1        (ID_valid_1),
        .Way_0_oldest_ID   (Way_0_oldest_ID),
        .issue_0           (issue_0),
        .issue_1           (issue_1),
        .fetch_count       (fetch_count),
        .stall_cnt         (stall_cnt),
        .issue_cnt         (issue_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: slot contents, age, counters.
    slot_t       m_slot [2];
    logic        m_old;
    logic [31:0] m_icnt, m_scnt;
    bit          m_known = 1'b0;
    logic [1:0]  e_iss;
    int          e_fc;
    int          m_keep;
    logic [31:0] fetch_pc     = 32'h0000_1000;
    logic [31:0] exp_issue_pc = 32'h0000_1000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected issue and fetch consumption from current model state and inputs.
    task automatic model_comb();
        int  o;
        int  w;
        int  nf;
        bit  blocked;
        logic [1:0] haz;
        haz     = {hazard_detected_1, hazard_detected_0};
        e_iss   = 2'b00;
        e_fc    = 0;
        m_keep  = 0;
        blocked = 1'b0;
        o       = m_old ? 0 : 1;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? o : 1 - o;
            if (m_slot[w].valid) begin
                if (!blocked && !haz[w] && !rst && !Flush_0) e_iss[w] = 1'b1;
                else begin
                    blocked = 1'b1;
                    m_keep++;
                end
            end
        end
        if (!rst && !Flush_0) begin
            nf   = int'(IF_valid_0) + int'(IF_valid_1);
            e_fc = (2 - m_keep < nf) ? 2 - m_keep : nf;
        end
    endtask

    task automatic compare();
        int o;
        int w;
        chk("issue_0", issue_0, e_iss[0]);
        chk("issue_1", issue_1, e_iss[1]);
        chk("fetch_count", fetch_count, e_fc);
        if (m_known) begin
            chk("valid_0", ID_valid_0, m_slot[0].valid);
            chk("valid_1", ID_valid_1, m_slot[1].valid);
            chk("inst_0", ID_inst_0, m_slot[0].valid ? m_slot[0].inst : NOP_INST);
            chk("inst_1", ID_inst_1, m_slot[1].valid ? m_slot[1].inst : NOP_INST);
            if (m_slot[0].valid) chk("pc_0", ID_pc_0, m_slot[0].pc);
            if (m_slot[1].valid) chk("pc_1", ID_pc_1, m_slot[1].pc);
            chk("oldest", Way_0_oldest_ID, m_old);
            chk("issue_cnt", issue_cnt, m_icnt);
            chk("stall_cnt", stall_cnt, m_scnt);
            // Issued instructions must form a contiguous program-order PC stream.
            o = m_old ? 0 : 1;
            for (int k = 0; k < 2; k++) begin
                w = (k == 0) ? o : 1 - o;
                if (e_iss[w]) begin
                    chk("issue_pc_order", (w == 0) ? ID_pc_0 : ID_pc_1, exp_issue_pc);
                    exp_issue_pc = exp_issue_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic apply(input bit r, input bit iv0, input bit iv1, input bit h0, input bit h1,
                         input bit fl, input logic [31:0] i0, input logic [31:0] i1);
        @(negedge clk);
        rst               = r;
        IF_valid_0        = iv0;
        IF_valid_1        = iv0 & iv1;
        IF_inst_0         = i0;
        IF_inst_1         = i1;
        IF_pc_0           = fetch_pc;
        IF_pc_1           = fetch_pc + 32'd4;
        hazard_detected_0 = h0;
        hazard_detected_1 = h1;
        Flush_0           = fl;
        Flush_1           = fl;
        #2;
        model_comb();
        compare();
    endtask

    // Advance the model across the clock edge.
    task automatic tick();
        slot_t order [$];
        slot_t ent [2];
        int    o;
        int    w;
        int    sw;
        @(posedge clk);
        if (rst) begin
            m_slot[0] = '0;
            m_slot[1] = '0;
            m_old     = 1'b1;
            m_icnt    = 0;
            m_scnt    = 0;
            m_known   = 1'b1;
            exp_issue_pc = fetch_pc;
        end else if (Flush_0) begin
            m_slot[0] = '0;
            m_slot[1] = '0;
            m_old     = 1'b1;
            exp_issue_pc = fetch_pc;
        end else begin
            m_icnt = m_icnt + 32'(e_iss[0]) + 32'(e_iss[1]);
            if (m_keep > 0) m_scnt = m_scnt + 32'd1;
            ent[0] = '{valid: 1'b1, inst: IF_inst_0, pc: IF_pc_0};
            ent[1] = '{valid: 1'b1, inst: IF_inst_1, pc: IF_pc_1};
            o  = m_old ? 0 : 1;
            sw = 0;
            for (int k = 0; k < 2; k++) begin
                w = (k == 0) ? o : 1 - o;
                if (m_slot[w].valid && !e_iss[w]) begin
                    order.push_back(m_slot[w]);
                    sw = w;
                end
            end
            for (int j = 0; j < e_fc; j++) order.push_back(ent[j]);
            if (m_keep == 1) begin
                m_old          = (sw == 0);
                m_slot[1 - sw] = (order.size() > 1) ? order[1] : slot_t'('0);
            end else if (m_keep == 0) begin
                m_old     = 1'b1;
                m_slot[0] = (order.size() > 0) ? order[0] : slot_t'('0);
                m_slot[1] = (order.size() > 1) ? order[1] : slot_t'('0);
            end
            fetch_pc = fetch_pc + 32'(4 * e_fc);
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit r, fl, iv0, iv1, h0, h1;
        m_slot[0] = '0;
        m_slot[1] = '0;
        m_old = 1'b1;
        m_icnt = 0;
        m_scnt = 0;
        rst = 1'b1;
        IF_inst_0 = '0; IF_inst_1 = '0; IF_pc_0 = '0; IF_pc_1 = '0;
        IF_valid_0 = 1'b0; IF_valid_1 = 1'b0;
        hazard_detected_0 = 1'b0; hazard_detected_1 = 1'b0;
        Flush_0 = 1'b0; Flush_1 = 1'b0;

        // Reset
        apply(1, 0, 0, 0, 0, 0, 0, 0); tick();
        apply(1, 0, 0, 0, 0, 0, 0, 0); tick();

        // Load a pair into an empty buffer
        apply(0, 1, 1, 0, 0, 0, I_ADD, I_SUB);
        chk("lit_rst_valid_0", ID_valid_0, 1'b0);
        chk("lit_rst_oldest", Way_0_oldest_ID, 1'b1);
        chk("lit_load_fetch_count", fetch_count, 2'd2);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_pair_valid_0", ID_valid_0, 1'b1);
        chk("lit_pair_valid_1", ID_valid_1, 1'b1);
        chk("lit_pair_inst_0", ID_inst_0, I_ADD);
        chk("lit_pair_inst_1", ID_inst_1, I_SUB);
        chk("lit_pair_issue_both", {issue_1, issue_0}, 2'b11);
        tick();

        // Younger way stalls; older issues, survivor becomes oldest
        apply(0, 1, 1, 0, 0, 0, I_A, I_B); tick();
        apply(0, 1, 1, 0, 1, 0, I_C, I_D);
        chk("lit_h1_issue", {issue_1, issue_0}, 2'b01);
        chk("lit_h1_fetch_count", fetch_count, 2'd1);
        tick();
        apply(0, 0, 0, 1, 1, 0, 0, 0);
        chk("lit_h1_oldest", Way_0_oldest_ID, 1'b0);
        chk("lit_h1_inst_1", ID_inst_1, I_B);
        chk("lit_h1_inst_0", ID_inst_0, I_C);
        tick();
        // Hazard on the oldest (way 1) only: nothing issues
        apply(0, 0, 0, 0, 1, 0, 0, 0);
        chk("lit_old_haz_issue", {issue_1, issue_0}, 2'b00);
        chk("lit_old_haz_fetch", fetch_count, 2'd0);
        tick();

        // Flush with a pending hazard
        apply(0, 1, 1, 0, 1, 1, I_A, I_B);
        chk("lit_flush_issue", {issue_1, issue_0}, 2'b00);
        chk("lit_flush_fetch", fetch_count, 2'd0);
        tick();
        apply(0, 1, 0, 0, 0, 0, I_E, 0);
        chk("lit_flush_valids", {ID_valid_1, ID_valid_0}, 2'b00);
        chk("lit_flush_inst_0", ID_inst_0, 32'h0);
        chk("lit_flush_oldest", Way_0_oldest_ID, 1'b1);
        tick();

        // Single fetch entry into an empty buffer
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_single_valids", {ID_valid_1, ID_valid_0}, 2'b01);
        chk("lit_single_inst_0", ID_inst_0, I_E);
        chk("lit_single_issue", {issue_1, issue_0}, 2'b01);
        tick();

        // Reset during a stall
        apply(0, 1, 1, 0, 0, 0, I_A, I_B); tick();
        apply(1, 0, 0, 1, 1, 0, 0, 0);
        chk("lit_rst_stall_issue", {issue_1, issue_0}, 2'b00);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_rst_stall_valids", {ID_valid_1, ID_valid_0}, 2'b00);
        chk("lit_rst_stall_oldest", Way_0_oldest_ID, 1'b1);
        chk("lit_rst_stall_icnt", issue_cnt, 32'd0);
        tick();

        // Streaming independent pairs
        apply(0, 1, 1, 0, 0, 0, I_A, I_B); tick();
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 1, 0, 0, 0, I_C, I_D);
            chk("lit_stream_issue", {issue_1, issue_0}, 2'b11);
            tick();
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_stream_icnt", issue_cnt, 32'd8);
        chk("lit_stream_scnt", stall_cnt, 32'd0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            fl  = ($urandom_range(0, 24) == 0);
            iv0 = ($urandom_range(0, 3) != 0);
            iv1 = iv0 && ($urandom_range(0, 2) != 0);
            h0  = ($urandom_range(0, 9) < 3);
            h1  = ($urandom_range(0, 9) < 3);
            apply(r, iv0, iv1, h0, h1, fl, $urandom, $urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
